stim_prog_arbiter: RTL and testbench
====================================

Name: stim_prog_arbiter

Overview:
- Shares the stimulation-sequencer programming bus between two requesters: the host (USB wire-in path) and the on-FPGA closed-loop controller.
- The bus is prog_module/prog_address/prog_word/prog_trig, consumed by all analog_out and stim sequencer modules.
- Serialises register writes, generates a clean prog_trig strobe with guaranteed setup and hold around it, and issues writes only while the top level asserts prog_allow (outside the main_state stim window).
- Sits between the host/closed-loop logic and the sequencer bank, clocked by dataclk.

Parameters:
SETUP_CYCLES, 2, dataclk cycles the bus fields are stable before prog_trig rises (>=1)
HIGH_CYCLES, 2, prog_trig high duration in cycles (>=1)
HOLD_CYCLES, 2, cycles the fields are held after prog_trig falls (>=1)
CL_FIFO_DEPTH, 4, closed-loop request FIFO depth (power of 2, >=2)

Ports:
dataclk  in  1  system clock
reset  in  1  synchronous, active-high reset
host_valid  in  1  host write request
host_ready  out  1  host holding register empty
host_module  in  5  target module index
host_address  in  4  target register address
host_word  in  16  register data
cl_valid  in  1  closed-loop write request
cl_ready  out  1  closed-loop FIFO not full
cl_module  in  5  target module index
cl_address  in  4  target register address
cl_word  in  16  register data
prog_allow  in  1  issuance permitted this cycle
prog_module  out  5  bus module field
prog_address  out  4  bus address field
prog_word  out  16  bus data field
prog_trig  out  1  write strobe (sequencers latch on its rising edge)
busy  out  1  transaction in progress (state != IDLE)
grant_src  out  1  source of current/last write (0 = host, 1 = closed-loop)
cl_fifo_count  out  $clog2(CL_FIFO_DEPTH)+1  closed-loop FIFO occupancy

Behaviour:
- Single clock dataclk. reset is synchronous, active-high.
- Reset values: all prog_* outputs 0; busy 0; grant_src 0; FIFO empty; host holding register empty; round-robin pointer favours host.
- Reset mid-transaction aborts immediately: prog_trig 0 on the next edge, and pending requests are discarded.
- Host path: one-entry holding register.
  - host_ready = ~host_pending (from register, no bypass).
  - The transfer occurs when host_valid && host_ready.
  - host_ready returns high the cycle after the entry is granted.
- Closed-loop path: FIFO of depth CL_FIFO_DEPTH.
  - Push when cl_valid && cl_ready; cl_ready = count != CL_FIFO_DEPTH.
  - A push and a pop in the same cycle leave count unchanged.
  - A push into an empty FIFO is not grantable until the next cycle.
- FSM states: IDLE, SETUP, STROBE, HOLD. A shared down-counter counts cycles within each state.
  - IDLE: if prog_allow and at least one source is pending, grant a source and go to SETUP.
    - If both sources are pending, grant the one not granted last (round-robin). Otherwise grant the only pending source.
    - On the grant edge, latch the fields onto prog_*, set grant_src, pop/clear the source, and load counter = SETUP_CYCLES-1.
  - SETUP: prog_trig 0. When counter == 0, go to STROBE with counter = HIGH_CYCLES-1 and prog_trig 1.
  - STROBE: prog_trig 1. When counter == 0, go to HOLD with counter = HOLD_CYCLES-1 and prog_trig 0.
  - HOLD: prog_trig 0, fields held. When counter == 0, go to IDLE.
- Latency:
  - Request visible in IDLE at edge N: fields are valid after edge N+1; prog_trig rises at edge N+1+SETUP_CYCLES.
  - One write occupies 1+SETUP_CYCLES+HIGH_CYCLES+HOLD_CYCLES cycles, including the IDLE decision cycle.
- prog_allow is sampled only in IDLE. Deassertion mid-transaction does not abort or stretch the transaction.
- In IDLE, prog_* fields keep the last written values; prog_trig is always 0 outside STROBE.
- No write is ever dropped. Back-pressure is solely through the ready signals.

Decomposition:
- Shared package (stim_prog_pkg):
  - bus field widths: MODULE_W = 5, ADDR_W = 4, WORD_W = 16
  - FSM state encoding
  - grant source constants SRC_HOST / SRC_CL
  - a packed request struct {module, address, word}
- Sub-module: prog_req_fifo, a synchronous FIFO of the request struct with push/pop/count, instantiated for the closed-loop path.

Test Plan:
- Host writes module 3, addr 10, word 0x8200 with prog_allow=1 and defaults → prog_module=3, prog_address=10, prog_word=0x8200 stable for 2 cycles before prog_trig, trig high for 2 cycles, held for 2 cycles after; host_ready high again 1 cycle after grant.
- Both sources pending simultaneously, with host holding addr 4 and CL FIFO holding addr 5 and 6 → bus order 4, 5, then 6. A new host request arriving during write 5 is granted before 6, giving alternation.
- Push 4 CL requests back-to-back with prog_allow=0 → cl_fifo_count=4, cl_ready=0, no prog_trig. Raise prog_allow → 4 writes in FIFO order, each taking 7 cycles, with cl_ready reasserting after the first pop.
- prog_allow drops during STROBE → current write completes normally; the next pending request waits until prog_allow=1.
- reset asserted during SETUP with 2 entries queued → next cycle all outputs 0, busy=0, cl_fifo_count=0, host_ready=1; no prog_trig pulse occurs.
- Parameter sweep SETUP=1/HIGH=1/HOLD=1 → 4-cycle transactions, prog_trig a single-cycle pulse.

Source files
------------

// File: rtl/stim_prog_pkg.sv
// Shared definitions for the stimulation programming-bus arbiter.
// Holds the bus field widths, the arbiter FSM encoding, the grant-source
// constants and the packed request record carried through the host
// holding register and the closed-loop FIFO.
package stim_prog_pkg;

  localparam int MODULE_W = 5;
  localparam int ADDR_W   = 4;
  localparam int WORD_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } prog_state_e;

  localparam logic SRC_HOST = 1'b0;
  localparam logic SRC_CL   = 1'b1;

  typedef struct packed {
    logic [MODULE_W-1:0] mod;
    logic [ADDR_W-1:0]   addr;
    logic [WORD_W-1:0]   word;
  } prog_req_t;

endpackage

// File: rtl/prog_req_fifo.sv
// Synchronous FIFO of programming requests (closed-loop write path).
// Ports:
//   clk, reset      : clock, synchronous active-high reset (empties FIFO)
//   push, din       : write a request (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   dout            : head entry (valid while count != 0)
//   count           : occupancy, 0..DEPTH
//   full, empty     : occupancy flags
// A push and a pop in the same cycle leave count unchanged. The head of an
// empty FIFO only becomes visible after the pushing edge, so a freshly
// pushed entry is not usable in the cycle it is written.
module prog_req_fifo
  import stim_prog_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  prog_req_t                din,
  output prog_req_t                dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  prog_req_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stim_prog_arbiter.sv
// Arbiter for the stimulation-sequencer programming bus.
// Two requesters share prog_module/prog_address/prog_word/prog_trig: the
// host (one-entry holding register) and the closed-loop controller (FIFO).
// Each write presents the fields for SETUP_CYCLES before prog_trig rises,
// keeps prog_trig high for HIGH_CYCLES, then holds the fields for
// HOLD_CYCLES. A new write is only started from IDLE while prog_allow=1.
// Ports:
//   dataclk, reset                : clock, synchronous active-high reset
//   host_valid/ready/module/...   : host request, valid/ready handshake
//   cl_valid/ready/module/...     : closed-loop request, valid/ready
//   prog_allow                    : issuance permitted (sampled in IDLE)
//   prog_module/address/word/trig : programming bus
//   busy                          : transaction in progress
//   grant_src                     : source of current/last write
//   cl_fifo_count                 : closed-loop FIFO occupancy
// Handshake: a request transfers on any edge where valid && ready are both
// high; ready depends only on registered state, never on valid.
module stim_prog_arbiter
  import stim_prog_pkg::*;
#(
  parameter int SETUP_CYCLES  = 2,
  parameter int HIGH_CYCLES   = 2,
  parameter int HOLD_CYCLES   = 2,
  parameter int CL_FIFO_DEPTH = 4
) (
  input  logic                             dataclk,
  input  logic                             reset,
  input  logic                             host_valid,
  output logic                             host_ready,
  input  logic [MODULE_W-1:0]              host_module,
  input  logic [ADDR_W-1:0]                host_address,
  input  logic [WORD_W-1:0]                host_word,
  input  logic                             cl_valid,
  output logic                             cl_ready,
  input  logic [MODULE_W-1:0]              cl_module,
  input  logic [ADDR_W-1:0]                cl_address,
  input  logic [WORD_W-1:0]                cl_word,
  input  logic                             prog_allow,
  output logic [MODULE_W-1:0]              prog_module,
  output logic [ADDR_W-1:0]                prog_address,
  output logic [WORD_W-1:0]                prog_word,
  output logic                             prog_trig,
  output logic                             busy,
  output logic                             grant_src,
  output logic [$clog2(CL_FIFO_DEPTH):0]   cl_fifo_count
);

  // Phase counter; phase lengths must not exceed 256 cycles.
  localparam int CNT_W = 8;

  prog_state_e        state;
  prog_state_e        state_d;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_d;

  logic               host_pending;
  prog_req_t          host_req;
  prog_req_t          cl_head;
  logic               cl_full;
  logic               cl_empty;
  logic               last_cl;      // 1 when the previous grant went to closed-loop
  logic               grant;
  logic               grant_cl;

  assign host_ready = ~host_pending;
  assign cl_ready   = ~cl_full;
  assign busy       = (state != ST_IDLE);

  prog_req_fifo #(
    .DEPTH (CL_FIFO_DEPTH)
  ) u_cl_fifo (
    .clk   (dataclk),
    .reset (reset),
    .push  (cl_valid && cl_ready),
    .pop   (grant && grant_cl),
    .din   ('{mod: cl_module, addr: cl_address, word: cl_word}),
    .dout  (cl_head),
    .count (cl_fifo_count),
    .full  (cl_full),
    .empty (cl_empty)
  );

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    grant    = 1'b0;
    grant_cl = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (prog_allow && (host_pending || !cl_empty)) begin
          grant    = 1'b1;
          // With both pending, the source not served last wins.
          grant_cl = !cl_empty && (!host_pending || !last_cl);
          state_d  = ST_SETUP;
          cnt_d    = CNT_W'(SETUP_CYCLES - 1);
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_d = ST_STROBE;
          cnt_d   = CNT_W'(HIGH_CYCLES - 1);
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge dataclk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      prog_trig    <= 1'b0;
      prog_module  <= '0;
      prog_address <= '0;
      prog_word    <= '0;
      grant_src    <= SRC_HOST;
      last_cl      <= 1'b1;      // host wins the first contested grant
      host_pending <= 1'b0;
      host_req     <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      // Registered strobe: high exactly while the FSM sits in STROBE.
      prog_trig <= (state_d == ST_STROBE);
      if (grant) begin
        if (grant_cl) begin
          prog_module  <= cl_head.mod;
          prog_address <= cl_head.addr;
          prog_word    <= cl_head.word;
        end else begin
          prog_module  <= host_req.mod;
          prog_address <= host_req.addr;
          prog_word    <= host_req.word;
        end
        grant_src <= grant_cl ? SRC_CL : SRC_HOST;
        last_cl   <= grant_cl;
      end
      if (grant && !grant_cl) begin
        host_pending <= 1'b0;
      end else if (host_valid && host_ready) begin
        host_pending <= 1'b1;
        host_req     <= '{mod: host_module, addr: host_address, word: host_word};
      end
    end
  end

endmodule

// File: tb/tb_stim_prog_arbiter.sv
`timescale 1ns/1ps
module tb_stim_prog_arbiter;
  import stim_prog_pkg::*;

  localparam int S = 2;
  localparam int H = 2;
  localparam int D = 2;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic [4:0]    host_module = '0;
  logic [3:0]    host_address = '0;
  logic [15:0]   host_word = '0;
  logic          cl_valid = 1'b0;
  logic          cl_ready;
  logic [4:0]    cl_module = '0;
  logic [3:0]    cl_address = '0;
  logic [15:0]   cl_word = '0;
  logic          prog_allow = 1'b0;
  logic [4:0]    prog_module;
  logic [3:0]    prog_address;
  logic [15:0]   prog_word;
  logic          prog_trig;
  logic          busy;
  logic          grant_src;
  logic [CW-1:0] cl_fifo_count;

  stim_prog_arbiter #(
    .SETUP_CYCLES(S), .HIGH_CYCLES(H), .HOLD_CYCLES(D), .CL_FIFO_DEPTH(DEPTH)
  ) dut (
    .dataclk(clk), .reset(reset),
    .host_valid(host_valid), .host_ready(host_ready), .host_module(host_module),
    .host_address(host_address), .host_word(host_word),
    .cl_valid(cl_valid), .cl_ready(cl_ready), .cl_module(cl_module),
    .cl_address(cl_address), .cl_word(cl_word),
    .prog_allow(prog_allow),
    .prog_module(prog_module), .prog_address(prog_address), .prog_word(prog_word),
    .prog_trig(prog_trig), .busy(busy), .grant_src(grant_src),
    .cl_fifo_count(cl_fifo_count)
  );

  // Second instance with 1/1/1 timing, exercised only by the sweep.
  logic          reset_f = 1'b1;
  logic          cl_valid_f = 1'b0;
  logic [3:0]    cl_address_f = '0;
  logic          prog_allow_f = 1'b0;
  logic          host_ready_f, cl_ready_f, prog_trig_f, busy_f, grant_src_f;
  logic [4:0]    prog_module_f;
  logic [3:0]    prog_address_f;
  logic [15:0]   prog_word_f;
  logic [CW-1:0] cl_fifo_count_f;

  stim_prog_arbiter #(
    .SETUP_CYCLES(1), .HIGH_CYCLES(1), .HOLD_CYCLES(1), .CL_FIFO_DEPTH(DEPTH)
  ) dut_f (
    .dataclk(clk), .reset(reset_f),
    .host_valid(1'b0), .host_ready(host_ready_f), .host_module(5'd0),
    .host_address(4'd0), .host_word(16'd0),
    .cl_valid(cl_valid_f), .cl_ready(cl_ready_f), .cl_module(5'd2),
    .cl_address(cl_address_f), .cl_word(16'h1234),
    .prog_allow(prog_allow_f),
    .prog_module(prog_module_f), .prog_address(prog_address_f), .prog_word(prog_word_f),
    .prog_trig(prog_trig_f), .busy(busy_f), .grant_src(grant_src_f),
    .cl_fifo_count(cl_fifo_count_f)
  );

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction-level view: a write starts on a grant edge; m_t counts the
  // edges since then. The strobe is high for phase offsets [S, S+H) and the
  // write ends after S+H+D cycles.
  bit         started = 0;
  bit         m_hpend = 0;
  prog_req_t  m_hreq;
  prog_req_t  mq[$];
  bit         m_active = 0;
  int         m_t = 0;
  bit         m_last_cl = 1;
  logic [4:0] m_mod = '0;
  logic [3:0] m_addr = '0;
  logic [15:0] m_word = '0;
  bit         m_src = 0;

  always @(posedge clk) begin : model
    prog_req_t r;
    bit push, hacc, gcl;
    started = 1;
    if (reset) begin
      m_hpend = 0; mq.delete(); m_active = 0; m_t = 0; m_last_cl = 1;
      m_mod = '0; m_addr = '0; m_word = '0; m_src = 0;
    end else begin
      push = cl_valid && (mq.size() < DEPTH);
      hacc = host_valid && !m_hpend;
      if (!m_active) begin
        if (prog_allow && (m_hpend || mq.size() != 0)) begin
          if (m_hpend && mq.size() != 0) gcl = !m_last_cl;
          else gcl = (mq.size() != 0);
          if (gcl) r = mq.pop_front();
          else begin r = m_hreq; m_hpend = 0; end
          m_mod = r.mod; m_addr = r.addr; m_word = r.word;
          m_src = gcl; m_last_cl = gcl; m_active = 1; m_t = 0;
        end
      end else if (m_t == S + H + D - 1) begin
        m_active = 0;
      end else begin
        m_t++;
      end
      if (push) begin
        r.mod = cl_module; r.addr = cl_address; r.word = cl_word;
        mq.push_back(r);
      end
      if (hacc) begin
        m_hpend = 1;
        m_hreq.mod = host_module; m_hreq.addr = host_address; m_hreq.word = host_word;
      end
    end
  end

  // Compare every cycle, on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      check("host_ready", host_ready, !m_hpend);
      check("cl_ready", cl_ready, mq.size() < DEPTH);
      check("cl_fifo_count", cl_fifo_count, mq.size());
      check("busy", busy, m_active);
      check("prog_trig", prog_trig, m_active && m_t >= S && m_t < S + H);
      check("prog_module", prog_module, m_mod);
      check("prog_address", prog_address, m_addr);
      check("prog_word", prog_word, m_word);
      check("grant_src", grant_src, m_src);
    end
  end

  // ---------------- bus monitors (feed literal checks) ----------------
  int cyc = 0;
  int rise_addr[$];
  int rise_word[$];
  int rise_cyc[$];
  int hi_len[$];
  int cur_hi = 0;
  int fall_cyc = 0;
  int busy_rise_cyc = 0;
  int busy_fall_cyc = 0;
  bit prev_trig = 0;
  bit prev_busy = 0;

  int rise_addr_f[$];
  int rise_cyc_f[$];
  int hi_len_f[$];
  int cur_hi_f = 0;
  bit prev_trig_f = 0;

  always @(negedge clk) begin
    cyc++;
    if (prog_trig === 1'b1 && !prev_trig) begin
      rise_addr.push_back(int'(prog_address));
      rise_word.push_back(int'(prog_word));
      rise_cyc.push_back(cyc);
      cur_hi = 0;
    end
    if (prog_trig === 1'b1) cur_hi++;
    if (prog_trig !== 1'b1 && prev_trig) begin
      hi_len.push_back(cur_hi);
      fall_cyc = cyc;
    end
    if (busy === 1'b1 && !prev_busy) busy_rise_cyc = cyc;
    if (busy !== 1'b1 && prev_busy) busy_fall_cyc = cyc;
    prev_trig = (prog_trig === 1'b1);
    prev_busy = (busy === 1'b1);

    if (prog_trig_f === 1'b1 && !prev_trig_f) begin
      rise_addr_f.push_back(int'(prog_address_f));
      rise_cyc_f.push_back(cyc);
      cur_hi_f = 0;
    end
    if (prog_trig_f === 1'b1) cur_hi_f++;
    if (prog_trig_f !== 1'b1 && prev_trig_f) hi_len_f.push_back(cur_hi_f);
    prev_trig_f = (prog_trig_f === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic host_write(input logic [4:0] m, input logic [3:0] a, input logic [15:0] w);
    int guard = 0;
    while (!host_ready && guard < 200) begin tick(); guard++; end
    if (!host_ready) check("host_ready_timeout", 0, 1);
    host_valid = 1; host_module = m; host_address = a; host_word = w;
    tick();
    host_valid = 0;
  endtask

  task automatic cl_push(input logic [4:0] m, input logic [3:0] a, input logic [15:0] w);
    int guard = 0;
    while (!cl_ready && guard < 200) begin tick(); guard++; end
    if (!cl_ready) check("cl_ready_timeout", 0, 1);
    cl_valid = 1; cl_module = m; cl_address = a; cl_word = w;
    tick();
    cl_valid = 0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!(!busy && host_ready && cl_fifo_count == 0) && guard < 300) begin tick(); guard++; end
    if (busy || !host_ready || cl_fifo_count != 0) check("idle_timeout", 0, 1);
    tick(2);
  endtask

  task automatic wait_sig(input bit want_trig);
    int guard = 0;
    while (!(want_trig ? prog_trig : busy) && guard < 200) begin tick(); guard++; end
    if (!(want_trig ? prog_trig : busy)) check(want_trig ? "trig_timeout" : "busy_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1;
    tick(2);
    reset = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin : main
    int base, base2;

    // Reset state
    tick(2);
    check("rst_trig", prog_trig, 0);
    check("rst_busy", busy, 0);
    check("rst_host_ready", host_ready, 1);
    check("rst_count", cl_fifo_count, 0);
    check("rst_word", prog_word, 0);
    reset = 0;

    // Single host write, default timing
    prog_allow = 1;
    base = rise_addr.size();
    host_write(5'd3, 4'd10, 16'h8200);
    wait_idle();
    check("t1_nwrites", rise_addr.size() - base, 1);
    check("t1_addr", rise_addr[base], 10);
    check("t1_word", rise_word[base], 16'h8200);
    check("t1_setup", rise_cyc[base] - busy_rise_cyc, 2);
    check("t1_high", hi_len[base], 2);
    check("t1_hold", busy_fall_cyc - fall_cyc, 2);

    // Round-robin: host 4, CL 5 & 6, extra host 7 during write 5
    do_reset();
    prog_allow = 0;
    base = rise_addr.size();
    host_write(5'd1, 4'd4, 16'h0004);
    cl_push(5'd1, 4'd5, 16'h0005);
    cl_push(5'd1, 4'd6, 16'h0006);
    prog_allow = 1;
    tick(8);
    host_write(5'd1, 4'd7, 16'h0007);
    wait_idle();
    check("t2_nwrites", rise_addr.size() - base, 4);
    check("t2_order0", rise_addr[base], 4);
    check("t2_order1", rise_addr[base + 1], 5);
    check("t2_order2", rise_addr[base + 2], 7);
    check("t2_order3", rise_addr[base + 3], 6);

    // Fill FIFO with issuance blocked, then drain
    prog_allow = 0;
    base = rise_addr.size();
    for (int i = 0; i < 4; i++) cl_push(5'd9, 4'(i), 16'(16'hA000 + i));
    check("t3_full_count", cl_fifo_count, 4);
    check("t3_full_ready", cl_ready, 0);
    tick(3);
    check("t3_no_trig", rise_addr.size() - base, 0);
    prog_allow = 1;
    wait_idle();
    check("t3_nwrites", rise_addr.size() - base, 4);
    for (int i = 0; i < 4; i++) check("t3_order", rise_addr[base + i], i);
    for (int i = 1; i < 4; i++) check("t3_spacing", rise_cyc[base + i] - rise_cyc[base + i - 1], 7);

    // prog_allow drops during STROBE
    base = rise_addr.size();
    host_write(5'd4, 4'd9, 16'h0909);
    cl_push(5'd4, 4'd11, 16'h0B0B);
    wait_sig(1);
    prog_allow = 0;
    tick(15);
    check("t4_one_write", rise_addr.size() - base, 1);
    check("t4_first_addr", rise_addr[base], 9);
    check("t4_high", hi_len[hi_len.size() - 1], 2);
    check("t4_waiting", cl_fifo_count, 1);
    check("t4_idle", busy, 0);
    prog_allow = 1;
    wait_idle();
    check("t4_two_writes", rise_addr.size() - base, 2);
    check("t4_second_addr", rise_addr[base + 1], 11);

    // Reset during SETUP with two entries still queued
    prog_allow = 0;
    base = rise_addr.size();
    cl_push(5'd5, 4'd12, 16'h0C0C);
    cl_push(5'd5, 4'd13, 16'h0D0D);
    cl_push(5'd5, 4'd14, 16'h0E0E);
    prog_allow = 1;
    wait_sig(0);
    reset = 1;
    tick();
    check("t5_busy", busy, 0);
    check("t5_trig", prog_trig, 0);
    check("t5_count", cl_fifo_count, 0);
    check("t5_host_ready", host_ready, 1);
    check("t5_addr", prog_address, 0);
    check("t5_src", grant_src, 0);
    reset = 0;
    prog_allow = 0;
    tick(10);
    check("t5_no_pulse", rise_addr.size() - base, 0);

    // Timing sweep on the 1/1/1 instance
    reset_f = 0;
    prog_allow_f = 1;
    base2 = rise_addr_f.size();
    cl_valid_f = 1; cl_address_f = 4'd1;
    tick();
    cl_address_f = 4'd2;
    tick();
    cl_valid_f = 0;
    tick(12);
    check("sw_nwrites", rise_addr_f.size() - base2, 2);
    check("sw_addr0", rise_addr_f[base2], 1);
    check("sw_addr1", rise_addr_f[base2 + 1], 2);
    check("sw_spacing", rise_cyc_f[base2 + 1] - rise_cyc_f[base2], 4);
    check("sw_high0", hi_len_f[0], 1);
    check("sw_high1", hi_len_f[1], 1);
    check("sw_idle", busy_f, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
